// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-port bundle for ahb_sram_slave.
// The master modport is the interconnect/bench side; the slave modport is the SRAM responder side.
interface ahb_sram_slave_if;
  logic        slv_hsel_i;
  logic [1:0]  slv_htrans_i;
  logic [31:0] slv_haddr_i;
  logic        slv_hwrite_i;
  logic [2:0]  slv_hsize_i;
  logic [2:0]  slv_hburst_i;
  logic [3:0]  slv_hprot_i;
  logic        slv_hmastlock_i;
  logic [31:0] slv_hwdata_i;
  logic        slv_hready_i;
  logic        slv_hreadyout_o;
  logic        slv_hresp_o;
  logic [31:0] slv_hrdata_o;

  modport master (
    output slv_hsel_i, slv_htrans_i, slv_haddr_i, slv_hwrite_i, slv_hsize_i, slv_hburst_i,
           slv_hprot_i, slv_hmastlock_i, slv_hwdata_i, slv_hready_i,
    input  slv_hreadyout_o, slv_hresp_o, slv_hrdata_o
  );

  modport slave (
    input  slv_hsel_i, slv_htrans_i, slv_haddr_i, slv_hwrite_i, slv_hsize_i, slv_hburst_i,
           slv_hprot_i, slv_hmastlock_i, slv_hwdata_i, slv_hready_i,
    output slv_hreadyout_o, slv_hresp_o, slv_hrdata_o
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-organised SRAM with programmable wait states.
// Define AHB_SRAM_ERR_EN to enable the two-cycle ERROR response for bad address/size/alignment.
module ahb_sram_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  ahb_sram_slave_if.slave    slv
);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_write;
  logic [3:0]    r_strb;
  logic          r_hreadyout;
  logic          r_hresp;
  logic [31:0]   r_mem [DEPTH];

  logic       w_accept;
  logic       w_err;
  logic [3:0] w_strb;
  logic       w_unused;

  assign w_accept = slv.slv_hsel_i & slv.slv_htrans_i[1] & slv.slv_hready_i;

  // Oversized hsize falls into the word case.
  always_comb begin
    w_strb = 4'b1111;
    case (slv.slv_hsize_i)
      3'b000:  w_strb = 4'b0001 << slv.slv_haddr_i[1:0];
      3'b001:  w_strb = slv.slv_haddr_i[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ERR_EN
  assign w_err = (|(slv.slv_haddr_i >> (AW + 2)))
               | ((slv.slv_hsize_i == 3'b001) & slv.slv_haddr_i[0])
               | ((slv.slv_hsize_i == 3'b010) & (|slv.slv_haddr_i[1:0]))
               | (slv.slv_hsize_i > 3'b010);
  assign slv.slv_hresp_o = r_hresp;
`else
  assign w_err           = 1'b0;
  assign slv.slv_hresp_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_strb      <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        StWait: begin
          if (r_cnt == 4'd0) begin
            r_state     <= StData;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StErr1: begin
          r_state     <= StErr2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        // Idle, Data and Err2 all end a data phase and may accept the next address phase.
        default: begin
          if (w_accept) begin
            r_idx   <= slv.slv_haddr_i[AW+1:2];
            r_write <= slv.slv_hwrite_i;
            r_strb  <= w_strb;
            if (w_err) begin
              r_state     <= StErr1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_CYCLES > 0) begin
              r_state     <= StWait;
              r_cnt       <= 4'(WAIT_CYCLES - 1);
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= StData;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= StIdle;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  // SRAM array is deliberately not reset; writes land on the edge that closes the data phase.
  always_ff @(posedge clk) begin
    if (r_state == StData && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_strb[b]) r_mem[r_idx][8*b +: 8] <= slv.slv_hwdata_i[8*b +: 8];
      end
    end
  end

  assign slv.slv_hreadyout_o = r_hreadyout;
  assign slv.slv_hrdata_o    = (r_state == StData && !r_write) ? r_mem[r_idx] : 32'h0;

  assign w_unused = ^{slv.slv_hburst_i, slv.slv_hprot_i, slv.slv_hmastlock_i, slv.slv_haddr_i,
                      slv.slv_htrans_i[0], r_hresp};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: a zero-wait instance and a three-wait instance.
module tb_ahb_sram_slave;
  localparam logic [1:0] TrIdle = 2'b00, TrBusy = 2'b01, TrNs = 2'b10, TrSeq = 2'b11;
  localparam logic [2:0] SzB = 3'b000, SzH = 3'b001, SzW = 3'b010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ahb_sram_slave_if if0 ();
  ahb_sram_slave_if if1 ();

  assign if0.slv_hready_i = if0.slv_hreadyout_o;
  assign if1.slv_hready_i = if1.slv_hreadyout_o;

  ahb_sram_slave #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .slv   (if0)
  );

  ahb_sram_slave #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .slv   (if1)
  );

  task automatic cyc0(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    if0.slv_hsel_i = sel; if0.slv_htrans_i = tr; if0.slv_haddr_i = a;
    if0.slv_hwrite_i = wr; if0.slv_hsize_i = sz; if0.slv_hwdata_i = wd;
    @(posedge clk); #1;
  endtask

  task automatic cyc1(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                      input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    if1.slv_hsel_i = sel; if1.slv_htrans_i = tr; if1.slv_haddr_i = a;
    if1.slv_hwrite_i = wr; if1.slv_hsize_i = sz; if1.slv_hwdata_i = wd;
    @(posedge clk); #1;
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cyc1(1'b1, TrNs, a, 1'b1, SzW, 32'h0);
    while (if1.slv_hreadyout_o !== 1'b1 && n < 20) begin
      cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, d);
      n++;
    end
    cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, d);
  endtask

  task automatic read1(input logic [31:0] a, output logic [31:0] d, output int lows);
    lows = 0;
    cyc1(1'b1, TrNs, a, 1'b0, SzW, 32'h0);
    while (if1.slv_hreadyout_o !== 1'b1 && lows < 20) begin
      cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
      lows++;
    end
    d = if1.slv_hrdata_o;
    cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
  endtask

  task automatic test_reset;
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b1) $display("FAIL reset_rdy0: got %b want 1", if0.slv_hreadyout_o);
    else n_pass++;
    n_total++;
    if (if0.slv_hresp_o !== 1'b0) $display("FAIL reset_resp0: got %b want 0", if0.slv_hresp_o);
    else n_pass++;
    n_total++;
    if (if0.slv_hrdata_o !== 32'h0) $display("FAIL reset_rdata0: got %h want 0", if0.slv_hrdata_o);
    else n_pass++;
    n_total++;
    if (if1.slv_hreadyout_o !== 1'b1) $display("FAIL reset_rdy1: got %b want 1", if1.slv_hreadyout_o);
    else n_pass++;
  endtask

  task automatic test_write_read;
    cyc0(1'b1, TrNs, 32'h10, 1'b1, SzW, 32'h0);
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b1) $display("FAIL wr_rdy: got %b want 1", if0.slv_hreadyout_o);
    else n_pass++;
    cyc0(1'b1, TrNs, 32'h10, 1'b0, SzW, 32'hDEADBEEF);
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b1) $display("FAIL rd_rdy: got %b want 1", if0.slv_hreadyout_o);
    else n_pass++;
    n_total++;
    if (if0.slv_hrdata_o !== 32'hDEADBEEF)
      $display("FAIL wr_rd_back: got %h want deadbeef", if0.slv_hrdata_o);
    else n_pass++;
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
  endtask

  task automatic test_lane_strobes;
    cyc0(1'b1, TrNs, 32'h10, 1'b1, SzW, 32'h0);
    cyc0(1'b1, TrNs, 32'h13, 1'b1, SzB, 32'h11223344);
    cyc0(1'b1, TrNs, 32'h10, 1'b0, SzW, 32'hAABBCCDD);
    n_total++;
    if (if0.slv_hrdata_o !== 32'hAA223344)
      $display("FAIL byte_strobe: got %h want aa223344", if0.slv_hrdata_o);
    else n_pass++;
    cyc0(1'b1, TrNs, 32'h12, 1'b1, SzH, 32'h0);
    cyc0(1'b1, TrNs, 32'h10, 1'b0, SzW, 32'h5566EEFF);
    n_total++;
    if (if0.slv_hrdata_o !== 32'h55663344)
      $display("FAIL half_strobe: got %h want 55663344", if0.slv_hrdata_o);
    else n_pass++;
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
  endtask

  task automatic test_idle_busy;
    logic       sel_v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] tr_v  [4] = '{TrIdle, TrBusy, TrNs, TrSeq};
    for (int i = 0; i < 4; i++) begin
      cyc0(sel_v[i], tr_v[i], 32'h10, 1'b1, SzW, 32'hFFFFFFFF);
      n_total++;
      if (if0.slv_hreadyout_o !== 1'b1 || if0.slv_hresp_o !== 1'b0 || if0.slv_hrdata_o !== 32'h0)
        $display("FAIL noaccess_%0d: got rdy=%b resp=%b rdata=%h want 1 0 0", i,
                 if0.slv_hreadyout_o, if0.slv_hresp_o, if0.slv_hrdata_o);
      else n_pass++;
    end
    cyc0(1'b1, TrNs, 32'h10, 1'b0, SzW, 32'hFFFFFFFF);
    n_total++;
    if (if0.slv_hrdata_o !== 32'h55663344)
      $display("FAIL noaccess_mem: got %h want 55663344", if0.slv_hrdata_o);
    else n_pass++;
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
  endtask

  task automatic test_error;
    cyc0(1'b1, TrNs, 32'h0, 1'b1, SzW, 32'h0);
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h01020304);
`ifdef AHB_SRAM_ERR_EN
    cyc0(1'b1, TrNs, 32'h2, 1'b0, SzW, 32'h0);
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b0 || if0.slv_hresp_o !== 1'b1)
      $display("FAIL err1_rd: got rdy=%b resp=%b want 0 1", if0.slv_hreadyout_o, if0.slv_hresp_o);
    else n_pass++;
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b1 || if0.slv_hresp_o !== 1'b1 || if0.slv_hrdata_o !== 32'h0)
      $display("FAIL err2_rd: got rdy=%b resp=%b rdata=%h want 1 1 0", if0.slv_hreadyout_o,
               if0.slv_hresp_o, if0.slv_hrdata_o);
    else n_pass++;
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
    n_total++;
    if (if0.slv_hresp_o !== 1'b0) $display("FAIL err_clear: got %b want 0", if0.slv_hresp_o);
    else n_pass++;
    cyc0(1'b1, TrNs, 32'h1000, 1'b1, SzW, 32'h0);
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b0 || if0.slv_hresp_o !== 1'b1)
      $display("FAIL err1_wr: got rdy=%b resp=%b want 0 1", if0.slv_hreadyout_o, if0.slv_hresp_o);
    else n_pass++;
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'hCAFEF00D);
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'hCAFEF00D);
    cyc0(1'b1, TrNs, 32'h0, 1'b0, SzW, 32'h0);
    n_total++;
    if (if0.slv_hrdata_o !== 32'h01020304)
      $display("FAIL err_wr_suppressed: got %h want 01020304", if0.slv_hrdata_o);
    else n_pass++;
`else
    cyc0(1'b1, TrNs, 32'h1000, 1'b1, SzW, 32'h0);
    n_total++;
    if (if0.slv_hreadyout_o !== 1'b1 || if0.slv_hresp_o !== 1'b0)
      $display("FAIL alias_wr: got rdy=%b resp=%b want 1 0", if0.slv_hreadyout_o, if0.slv_hresp_o);
    else n_pass++;
    cyc0(1'b1, TrNs, 32'h0, 1'b0, SzW, 32'hCAFEF00D);
    n_total++;
    if (if0.slv_hrdata_o !== 32'hCAFEF00D)
      $display("FAIL alias_rd: got %h want cafef00d", if0.slv_hrdata_o);
    else n_pass++;
    cyc0(1'b1, TrNs, 32'h2, 1'b0, SzW, 32'h0);
    n_total++;
    if (if0.slv_hrdata_o !== 32'hCAFEF00D || if0.slv_hresp_o !== 1'b0)
      $display("FAIL misalign_rd: got %h resp=%b want cafef00d 0", if0.slv_hrdata_o,
               if0.slv_hresp_o);
    else n_pass++;
`endif
    cyc0(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
  endtask

  task automatic test_wait_states;
    int lows;
    write1(32'h20, 32'h12345678);
    write1(32'h24, 32'hA5A50F0F);
    cyc1(1'b1, TrNs, 32'h20, 1'b0, SzW, 32'h0);
    lows = 0;
    // Next address phase is held on the bus while this one is stalled.
    while (if1.slv_hreadyout_o !== 1'b1 && lows < 20) begin
      cyc1(1'b1, TrNs, 32'h24, 1'b0, SzW, 32'h0);
      lows++;
    end
    n_total++;
    if (lows != 3) $display("FAIL wait_count: got %0d want 3", lows);
    else n_pass++;
    n_total++;
    if (if1.slv_hrdata_o !== 32'h12345678 || if1.slv_hresp_o !== 1'b0)
      $display("FAIL wait_rdata: got %h resp=%b want 12345678 0", if1.slv_hrdata_o,
               if1.slv_hresp_o);
    else n_pass++;
    cyc1(1'b1, TrNs, 32'h24, 1'b0, SzW, 32'h0);
    n_total++;
    if (if1.slv_hreadyout_o !== 1'b0) $display("FAIL held_accept: got %b want 0",
                                                if1.slv_hreadyout_o);
    else n_pass++;
    lows = 1;
    while (if1.slv_hreadyout_o !== 1'b1 && lows < 20) begin
      cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
      if (if1.slv_hreadyout_o !== 1'b1) lows++;
    end
    n_total++;
    if (lows != 3 || if1.slv_hrdata_o !== 32'hA5A50F0F)
      $display("FAIL held_rdata: got lows=%0d rdata=%h want 3 a5a50f0f", lows, if1.slv_hrdata_o);
    else n_pass++;
    cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0);
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] d;
    int          lows;
    cyc1(1'b1, TrNs, 32'h20, 1'b1, SzW, 32'h0);
    cyc1(1'b0, TrIdle, 32'h0, 1'b0, SzW, 32'h0BADF00D);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (if1.slv_hreadyout_o !== 1'b1 || if1.slv_hresp_o !== 1'b0)
      $display("FAIL rst_mid_wait: got rdy=%b resp=%b want 1 0", if1.slv_hreadyout_o,
               if1.slv_hresp_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read1(32'h20, d, lows);
    n_total++;
    if (d !== 32'h12345678 || lows != 3)
      $display("FAIL rst_word_kept: got %h lows=%0d want 12345678 3", d, lows);
    else n_pass++;
  endtask

  initial begin
    if0.slv_hsel_i = 1'b0; if0.slv_htrans_i = TrIdle; if0.slv_haddr_i = 32'h0;
    if0.slv_hwrite_i = 1'b0; if0.slv_hsize_i = SzW; if0.slv_hwdata_i = 32'h0;
    if0.slv_hburst_i = 3'b000; if0.slv_hprot_i = 4'b0011; if0.slv_hmastlock_i = 1'b0;
    if1.slv_hsel_i = 1'b0; if1.slv_htrans_i = TrIdle; if1.slv_haddr_i = 32'h0;
    if1.slv_hwrite_i = 1'b0; if1.slv_hsize_i = SzW; if1.slv_hwdata_i = 32'h0;
    if1.slv_hburst_i = 3'b000; if1.slv_hprot_i = 4'b0011; if1.slv_hmastlock_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_lane_strobes();
    test_idle_busy();
    test_error();
    test_wait_states();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
